// File: rtl/wb_sdram_pkg.sv
// rtl/wb_sdram_pkg.sv - shared types and constants for the Wishbone SDRAM initiator
package wb_sdram_pkg;

  localparam int AW_DEF    = 24;
  localparam int DW_DEF    = 32;
  localparam int TIMEOUT_W = 16;

  typedef enum logic [1:0] {
    WAIT_INIT,
    IDLE,
    BUS,
    RESP
  } wbm_state_t;

endpackage

// File: rtl/wb_sdram_master_if.sv
// rtl/wb_sdram_master_if.sv - request/response port plus Wishbone initiator signals
interface wb_sdram_master_if import wb_sdram_pkg::*; #(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) ();

  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [AW-1:0]   req_addr;
  logic [DW-1:0]   req_wdata;
  logic [DW/8-1:0] req_sel;

  logic            rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;

  logic            cycle;
  logic            strb;
  logic            we;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   dat_o;
  logic [DW/8-1:0] sel;
  logic [DW-1:0]   dat_i;
  logic            ack;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, req_sel, dat_i, ack,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output cycle, strb, we, addr, dat_o, sel
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, req_sel, dat_i, ack,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  cycle, strb, we, addr, dat_o, sel
  );

endinterface

// File: rtl/wb_watchdog.sv
// rtl/wb_watchdog.sv - stall counter that flags the edge on which it reaches TIMEOUT
module wb_watchdog import wb_sdram_pkg::*; #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

  // Clear wins over count; each enabled edge adds one stalled cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expired on the edge that loads TIMEOUT, so the abort lands on that same edge.
  assign expired_o = en_i && (cnt_d == TIMEOUT_W'(TIMEOUT));

endmodule

// File: rtl/wb_sdram_master.sv
// rtl/wb_sdram_master.sv - single-cycle Wishbone classic initiator with watchdog abort
module wb_sdram_master import wb_sdram_pkg::*; #(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sdram_init_done,
  output logic [7:0]        err_cnt,
  wb_sdram_master_if.master bus
);

  wbm_state_t      state_q, state_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   dat_q, dat_d;
  logic [DW/8-1:0] sel_q, sel_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [7:0]      err_cnt_q, err_cnt_d;

  logic accept;
  logic wd_en;
  logic wd_expired;

  assign accept = (state_q == IDLE) && sdram_init_done && bus.req_valid;
  assign wd_en  = (state_q == BUS) && !bus.ack;

  wb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (accept),
    .en_i      (wd_en),
    .expired_o (wd_expired)
  );

  // Next state and bus/response register updates; ack has priority over the watchdog.
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    unique case (state_q)
      WAIT_INIT: begin
        if (sdram_init_done) state_d = IDLE;
      end
      IDLE: begin
        if (accept) begin
          state_d = BUS;
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          dat_d   = bus.req_wdata;
          sel_d   = bus.req_sel;
        end else if (!sdram_init_done) begin
          state_d = WAIT_INIT;
        end
      end
      BUS: begin
        if (bus.ack || wd_expired) begin
          state_d = RESP;
          we_d    = 1'b0;
          addr_d  = '0;
          dat_d   = '0;
          sel_d   = '0;
          if (bus.ack) begin
            rdata_d = we_q ? '0 : bus.dat_i;
            err_d   = 1'b0;
          end else begin
            rdata_d = '0;
            err_d   = 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = WAIT_INIT;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= WAIT_INIT;
      we_q      <= 1'b0;
      addr_q    <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // CYC and STB are the same flop-derived term so they can never disagree.
  assign bus.cycle     = (state_q == BUS);
  assign bus.strb      = (state_q == BUS);
  assign bus.we        = we_q;
  assign bus.addr      = addr_q;
  assign bus.dat_o     = dat_q;
  assign bus.sel       = sel_q;
  assign bus.req_ready = (state_q == IDLE) && sdram_init_done;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_wb_sdram_master.sv
// tb/tb_wb_sdram_master.sv - directed self-checking bench for wb_sdram_master
module tb_wb_sdram_master;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       init_done = 1'b0;
  logic [7:0] err_cnt;
  logic       rst_q = 1'b1;
  int         checks = 0;
  int         errors = 0;
  int         cyc_n = 0;
  int         acc_cyc = 0;

  wb_sdram_master_if #(.AW(24), .DW(32)) bus ();

  wb_sdram_master #(.AW(24), .DW(32), .TIMEOUT(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .sdram_init_done (init_done),
    .err_cnt         (err_cnt),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Cycle counter and registered view of reset for the protocol monitor.
  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    rst_q <= rst;
  end

  // Protocol monitor: STB implies CYC, and no CYC right after a reset edge.
  always @(negedge clk) begin
    if (bus.strb === 1'b1) check("stb_implies_cyc", {31'd0, bus.cycle}, 32'd1);
    if (rst_q) check("cyc_in_reset", {31'd0, bus.cycle}, 32'd0);
  end

  task automatic txn(input logic w, input logic [23:0] a, input logic [31:0] d,
                     input logic [3:0] s, input int stall, input logic [31:0] rd,
                     output int lat);
    int bad;
    bad = 0;
    lat = 0;
    bus.req_we    = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_sel   = s;
    bus.req_valid = 1'b1;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus.cycle && lat < 30);
    acc_cyc = cyc_n;
    bus.req_valid = 1'b0;
    check("acc_cyc_strb", {30'd0, bus.cycle, bus.strb}, 32'd3);
    check("acc_we", {31'd0, bus.we}, {31'd0, w});
    check("acc_addr", {8'd0, bus.addr}, {8'd0, a});
    check("acc_dat", bus.dat_o, d);
    check("acc_sel", {28'd0, bus.sel}, {28'd0, s});
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      if (!(bus.cycle && bus.strb && bus.we == w && bus.addr == a &&
            bus.dat_o == d && bus.sel == s && !bus.rsp_valid)) bad++;
    end
    check("bus_stable", bad, 0);
    bus.ack   = 1'b1;
    bus.dat_i = rd;
    @(posedge clk); #1;
    bus.ack   = 1'b0;
    bus.dat_i = 32'h0;
    check("end_cyc_strb", {30'd0, bus.cycle, bus.strb}, 32'd0);
    check("rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    check("rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    check("rsp_rdata", bus.rsp_rdata, w ? 32'h0 : rd);
    check("bus_idle", {31'd0, |{bus.we, bus.addr, bus.dat_o, bus.sel}}, 32'd0);
    @(posedge clk); #1;
    check("rsp_once", {31'd0, bus.rsp_valid}, 32'd0);
    check("ready_again", {31'd0, bus.req_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    int bad;
    int t0;
    int n;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_sel   = '0;
    bus.dat_i     = '0;
    bus.ack       = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, bus.req_ready}, 32'd0);
    check("rst_rsp", {30'd0, bus.rsp_valid, bus.rsp_err}, 32'd0);
    check("rst_rdata", bus.rsp_rdata, 32'h0);
    check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    check("rst_cyc_stb_we", {29'd0, bus.cycle, bus.strb, bus.we}, 32'd0);
    check("rst_addr", {8'd0, bus.addr}, 32'd0);
    check("rst_dat", bus.dat_o, 32'h0);
    check("rst_sel", {28'd0, bus.sel}, 32'd0);

    // Held off while init is low, then accepted two edges after init rises.
    rst = 1'b0;
    bus.req_we    = 1'b1;
    bus.req_addr  = 24'h000100;
    bus.req_wdata = 32'hDEADBEEF;
    bus.req_sel   = 4'hF;
    bus.req_valid = 1'b1;
    bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.req_ready || bus.cycle) bad++;
    end
    check("wait_init", bad, 0);
    init_done = 1'b1;
    txn(1'b1, 24'h000100, 32'hDEADBEEF, 4'hF, 2, 32'h0, lat);
    check("init_lat", lat, 2);

    // Reads, back to back with immediate ack.
    txn(1'b0, 24'h000100, 32'h0, 4'hF, 0, 32'hDEADBEEF, lat);
    check("rd_lat", lat, 1);
    t0 = acc_cyc;
    txn(1'b0, 24'h000104, 32'h0, 4'h3, 0, 32'h0BADF00D, lat);
    check("b2b_spacing", acc_cyc - t0, 3);

    // Never acked: abort after exactly 8 strobe cycles.
    bus.req_we    = 1'b0;
    bus.req_addr  = 24'h000200;
    bus.req_sel   = 4'hF;
    bus.dat_i     = 32'h12345678;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n = 0;
    while (bus.strb && n < 20) begin
      n++;
      @(posedge clk); #1;
    end
    check("to_strb_cycles", n, 8);
    check("to_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    check("to_rsp_err", {31'd0, bus.rsp_err}, 32'd1);
    check("to_rdata", bus.rsp_rdata, 32'h0);
    check("to_err_cnt", {24'd0, err_cnt}, 32'd1);
    bus.ack = 1'b1;
    @(posedge clk); #1;
    bus.ack   = 1'b0;
    bus.dat_i = 32'h0;
    check("late_ack_rsp", {30'd0, bus.rsp_valid, bus.cycle}, 32'd0);
    check("late_ack_rdata", bus.rsp_rdata, 32'h0);
    check("late_ack_ready", {31'd0, bus.req_ready}, 32'd1);

    // Ack on the edge the watchdog would expire: ack wins.
    txn(1'b0, 24'h000300, 32'h0, 4'hF, 7, 32'hCAFEF00D, lat);
    check("ack_wins_err_cnt", {24'd0, err_cnt}, 32'd1);

    // Init dropping in IDLE returns to WAIT_INIT.
    init_done = 1'b0;
    @(posedge clk); #1;
    init_done = 1'b1;
    check("idle_to_wait", {31'd0, bus.req_ready}, 32'd0);
    @(posedge clk); #1;
    check("wait_to_idle", {31'd0, bus.req_ready}, 32'd1);

    // Reset in the middle of a bus cycle.
    bus.req_we    = 1'b1;
    bus.req_addr  = 24'h000400;
    bus.req_wdata = 32'h55AA55AA;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("mid_rst_in_bus", {31'd0, bus.cycle}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_cyc_stb", {30'd0, bus.cycle, bus.strb}, 32'd0);
    check("mid_rst_fields", {31'd0, |{bus.we, bus.addr, bus.dat_o, bus.sel}}, 32'd0);
    check("mid_rst_rsp", {29'd0, bus.rsp_valid, bus.rsp_err, bus.req_ready}, 32'd0);
    check("mid_rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_no_rsp", {30'd0, bus.rsp_valid, bus.cycle}, 32'd0);
    check("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/wb_sdram_master.md
# wb_sdram_master

Wishbone classic-cycle initiator driving the SDRAM controller's Wishbone slave port. It accepts single read/write requests on a valid/ready port and holds them until `sdram_init_done` is high. It runs each request as one cyc/stb cycle, waits for `ack`, and returns a one-cycle response pulse. A watchdog aborts cycles that are never acknowledged. It is the bus-side stimulus engine for the SDRAM test environment, and its outputs must satisfy Wishbone rules 3.00–3.35 as checked on the controller side.

## Interface
- `AW`, 24: address width.
- `DW`, 32: data width; `DW/8` byte selects.
- `TIMEOUT`, 255: maximum number of cycles `strb` may stay high without `ack` before abort; legal range 1..65535.

Ports:
- `clk` in 1: sole clock; everything is updated on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `sdram_init_done` in 1: high means the controller has finished initialization.
- `req_valid` in 1: a request is offered.
- `req_ready` out 1: request accepted when `req_valid && req_ready` at a rising edge.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in AW: request address.
- `req_wdata` in DW: write data.
- `req_sel` in DW/8: byte selects.
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_rdata` out DW: read data; 0 for writes and aborts.
- `rsp_err` out 1: timeout abort flag, qualified by `rsp_valid`.
- `err_cnt` out 8: saturating count of aborts.
- `cycle`, `strb`, `we` out 1 each: Wishbone CYC_O, STB_O, WE_O.
- `addr` out AW, `dat_o` out DW, `sel` out DW/8: Wishbone address, write data and byte selects.
- `dat_i` in DW: Wishbone read data.
- `ack` in 1: Wishbone ACK_I.

## Operation
State machine with states WAIT_INIT, IDLE, BUS and RESP.
- **WAIT_INIT** (entered on reset): `req_ready` = 0. Moves to IDLE on the first edge with `sdram_init_done` = 1.
- **IDLE**:
  - `req_ready` = `sdram_init_done`.
  - On an accepted request, latch `we`/`addr`/`dat_o`/`sel` from the request, assert `cycle` and `strb`, clear the watchdog, and go to BUS.
  - If `sdram_init_done` = 0 with no request accepted, go to WAIT_INIT.
- **BUS**: `cycle` = `strb` = 1, and all bus outputs are held stable.
  - On `ack` = 1: capture `dat_i` if it is a read, deassert `cycle`/`strb`, and go to RESP with `rsp_err` = 0.
  - On watchdog = TIMEOUT without `ack`: deassert `cycle`/`strb`, force `rsp_rdata` = 0, set `rsp_err` = 1, increment `err_cnt` (saturating at 255), and go to RESP.
  - If `ack` arrives on the same edge the watchdog reaches TIMEOUT, `ack` wins: normal completion.
- **RESP**: `rsp_valid` = 1 for exactly one cycle, then go to IDLE. There is no backpressure on the response.
- `ack` outside BUS is ignored: no state change, no capture.
- `sdram_init_done` falling during BUS does not abort the cycle; the transaction completes or times out normally, then the block returns to WAIT_INIT via IDLE.
- `strb` = 1 always implies `cycle` = 1; the two rise together and fall together. Pipelined mode and block cycles are not used.
- `we`/`addr`/`dat_o`/`sel` return to 0 whenever `cycle` = 0.

## Timing
- Reset value of every output is 0: `req_ready`, `rsp_valid`, `rsp_rdata`, `rsp_err`, `err_cnt`, `cycle`, `strb`, `we`, `addr`, `dat_o`, `sel`.
- Reset is honoured at any edge, including mid-BUS: `cycle`/`strb` are 0 in the cycle after the reset edge, and any pending response is discarded.
- Request accepted at edge N → `cycle`/`strb` = 1 from N+1.
- `ack` sampled high at edge M → `cycle`/`strb` = 0 and `rsp_valid` = 1 during M+1 → `req_ready` = 1 again from M+2.
- Minimum transaction spacing is therefore 3 cycles: accept, ack edge, response.
- Watchdog:
  - Counts edges with `strb` = 1 and `ack` = 0, starting at 1 on the first such edge.
  - Abort occurs at the edge where the count equals TIMEOUT; `rsp_valid` with `rsp_err` = 1 appears the following cycle.
  - Counter width is 16 bits; it does not wrap because it is cleared on every accept.

## Structure
- Shared package `wb_sdram_pkg`:
  - state enum `wbm_state_t` {WAIT_INIT, IDLE, BUS, RESP};
  - default `AW`/`DW` constants;
  - `TIMEOUT_W` = 16.
- Sub-module `wb_watchdog`: clear input, count-enable input, 16-bit counter, `expired` output (count == TIMEOUT). All other logic lives in the top module.

## Test plan
1. Reset, then hold `sdram_init_done` = 0 for 20 cycles with `req_valid` = 1 → `req_ready` and `cycle` stay 0. Raise init_done → request accepted within 2 cycles.
2. Write `addr` = 0x000100, `wdata` = 0xDEADBEEF, `sel` = 0xF, with the slave acking 3 cycles after `strb` → bus fields stable throughout, `cycle`/`strb` drop the cycle after `ack`, `rsp_valid` pulses once with `rsp_err` = 0.
3. Read `addr` = 0x000100 with `dat_i` = 0xDEADBEEF on `ack` → `rsp_rdata` = 0xDEADBEEF; back-to-back reads achieve 3-cycle spacing.
4. `TIMEOUT` = 8, slave never acks → `strb` high for exactly 8 cycles, then `rsp_err` = 1, `rsp_rdata` = 0, `err_cnt` = 1. A late `ack` on the next cycle is ignored.
5. `ack` on exactly the 8th stalled cycle with `TIMEOUT` = 8 → normal completion, `rsp_err` = 0, `err_cnt` unchanged.
6. Assert `rst` mid-BUS → all outputs 0 the next cycle and no `rsp_valid`; a bound checker confirms `strb` → `cycle` and no `cycle` activity while `rst` = 1.
